l1_i_cache_controller: RTL
==========================

// Module: l1_i_cache_controller
// PURPOSE
//  Control FSM for the 2-way L1 instruction cache; sits upstream of L1_I_data_array and its tag array.
//  Latches core fetch requests, resolves hit/miss from tag-array results, selects the victim way
//  (invalid-first, then per-set 1-bit LRU) and fetches the 64B line from L2.
//  Drives index/offset plus refill/way into the data array.
// PARAMETERS
//  TNUM    21          tag bits, address[31:32-TNUM]
//  INUM    26-TNUM     index bits, address[6+:INUM]; 2**INUM sets
//  CNTW    16          width of saturating hit/miss counters
// PORTS
//  clk            in   1       single clock, all logic on posedge
//  nrst           in   1       synchronous, active-low reset
//  read_C_L1      in   1       core fetch request; sampled only in IDLE
//  address        in   32      fetch address; sampled with read_C_L1
//  ready_L1_C     out  1       1-cycle pulse: data on L1_I_data_array read_data_L1_C is valid
//  index_C_L1     out  INUM    latched index to tag/data arrays
//  offset         out  6       latched byte offset to data array
//  tag_C_L1       out  TNUM    latched tag to tag array (compare/write)
//  hit            in   1       tag-array hit for latched index/tag (combinational)
//  hit_way        in   1       way that hit; meaningful only when hit=1
//  valid_way      in   2       valid bits of way1/way0 at latched index
//  read_L1_L2     out  1       line request to L2; level, held until accepted
//  address_L1_L2  out  32      {tag, index, 6'd0}, line-aligned
//  ready_L2_L1    in   1       L2 line valid on read_data_L2_L1 this cycle
//  refill         out  1       data-array write enable (one cycle)
//  way            out  1       way for refill write, or hit way for read
//  update_tag     out  1       tag-array write enable (same cycle as refill)
//  cnt_hit        out  CNTW    saturating count of COMPARE hits
//  cnt_miss       out  CNTW    saturating count of COMPARE misses
// BEHAVIOUR
//  Reset (nrst=0 at posedge): state=IDLE; all outputs 0; lru[*]=0; counters 0. Applies in any state,
//   including MISS with L2 outstanding: read_L1_L2 drops next cycle, no refill issued.
//  IDLE: if read_C_L1=1, latch address into tag/index/offset regs -> COMPARE. Else stay.
//  COMPARE (1 cycle):
//   hit=1: ready_L1_C=1, way=hit_way, lru[index]<=~hit_way, cnt_hit++ (saturate at all-ones) -> IDLE.
//   hit=0: victim = way0 if !valid_way[0], else way1 if !valid_way[1], else lru[index].
//    Register victim; cnt_miss++ (saturate) -> MISS.
//  MISS: read_L1_L2=1, address_L1_L2={tag,index,6'd0}. ready_L2_L1 is sampled only here and ignored
//   elsewhere. On ready_L2_L1=1 -> REFILL (read_L1_L2 low from REFILL on).
//  REFILL (1 cycle): refill=1, update_tag=1, way=victim; lru[index]<=~victim -> COMPARE.
//   Re-compare must hit; the second COMPARE counts as a hit, so a miss costs +1 cnt_miss and +1 cnt_hit.
//  Latency:
//   - Hit: request sampled at cycle N; ready_L1_C at N+1; next request accepted at N+2.
//   - Miss: N+1 COMPARE, MISS from N+2, REFILL one cycle after ready_L2_L1, ready_L1_C two cycles after ready.
//  index_C_L1/offset/tag_C_L1 are stable from COMPARE through final ready_L1_C.
//  Held address input is ignored after latch.
//  Outputs not listed for a state are 0 in that state.
//  Exactly one of {hit path, miss path} per COMPARE; invalid X on hit_way when hit=0 is don't-care.
// TESTING
//  1 Reset: nrst=0 for 5 clk -> all outputs 0, cnt_hit=cnt_miss=0, state IDLE.
//  2 Cold miss: read 0x0000_0040, hit=0, valid_way=2'b00, ready_L2_L1 after 3 clk
//    -> read_L1_L2=1 with address_L1_L2=0x0000_0040; refill=1, way=0; ready_L1_C; cnt_miss=1, cnt_hit=1.
//  3 Hit: read 0x0000_0044, hit=1, hit_way=1 -> ready_L1_C 1 clk after request, way=1, lru[1]=0.
//  4 Replacement: index 2, valid_way=2'b11, prior hit on way0 -> victim way1;
//    then miss at same index -> victim way0 (LRU alternation).
//  5 Invalid-first: valid_way=2'b01 with lru=0 -> victim way1.
//  6 Reset mid-MISS: nrst=0 while read_L1_L2=1 -> read_L1_L2=0 next clk, no refill;
//    later ready_L2_L1 pulse ignored.

Source files
------------

// File: rtl/l1_i_cache_controller.sv
// ---------------------------------------------------------------------------------------------
// l1_i_cache_controller
//
// Control FSM for a 2-way L1 instruction cache. Latches a core fetch request, resolves hit/miss
// from the tag array's combinational result, picks a victim way on a miss (invalid way first,
// otherwise the per-set 1-bit LRU way), requests the 64B line from L2 and writes it back into
// the data/tag arrays before re-comparing.
//
// Ports
//   clk            clock, all logic on posedge
//   nrst           synchronous active-low reset
//   read_C_L1      core fetch request, sampled only while idle
//   address        fetch address, sampled with read_C_L1
//   ready_L1_C     one-cycle pulse: data array read data is valid
//   index_C_L1     latched set index to tag/data arrays
//   offset         latched byte offset to data array
//   tag_C_L1       latched tag to tag array (compare/write)
//   hit            tag-array hit for the latched index/tag
//   hit_way        way that hit (valid only with hit)
//   valid_way      valid bits {way1, way0} at the latched index
//   read_L1_L2     line request to L2, held until ready_L2_L1
//   address_L1_L2  line-aligned request address {tag, index, 6'd0}
//   ready_L2_L1    L2 line valid this cycle
//   refill         data-array write enable
//   way            refill way, or hit way for a read
//   update_tag     tag-array write enable, same cycle as refill
//   cnt_hit        saturating count of compare hits
//   cnt_miss       saturating count of compare misses
// ---------------------------------------------------------------------------------------------
module l1_i_cache_controller #(
    parameter int unsigned TNUM = 21,
    parameter int unsigned INUM = 26 - TNUM,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            read_C_L1,
    input  logic [31:0]     address,
    output logic            ready_L1_C,
    output logic [INUM-1:0] index_C_L1,
    output logic [5:0]      offset,
    output logic [TNUM-1:0] tag_C_L1,
    input  logic            hit,
    input  logic            hit_way,
    input  logic [1:0]      valid_way,
    output logic            read_L1_L2,
    output logic [31:0]     address_L1_L2,
    input  logic            ready_L2_L1,
    output logic            refill,
    output logic            way,
    output logic            update_tag,
    output logic [CNTW-1:0] cnt_hit,
    output logic [CNTW-1:0] cnt_miss
);

    localparam int unsigned Sets = 2 ** INUM;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StMiss,
        StRefill
    } state_e;

    state_e            state_q;
    logic [TNUM-1:0]   tag_q;
    logic [INUM-1:0]   index_q;
    logic [5:0]        offset_q;
    logic [Sets-1:0]   lru_q;       // per set: the way to evict next when both are valid
    logic              victim_q;
    logic              read_l2_q;
    logic              refill_q;
    logic [CNTW-1:0]   cnt_hit_q;
    logic [CNTW-1:0]   cnt_miss_q;
    logic              victim;
    logic              cmp_hit;

    // Invalid way first, then the LRU way of the set.
    always_comb begin
        if (!valid_way[0]) begin
            victim = 1'b0;
        end else if (!valid_way[1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[index_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= StIdle;
            tag_q      <= '0;
            index_q    <= '0;
            offset_q   <= '0;
            lru_q      <= '0;
            victim_q   <= 1'b0;
            read_l2_q  <= 1'b0;
            refill_q   <= 1'b0;
            cnt_hit_q  <= '0;
            cnt_miss_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (read_C_L1) begin
                        tag_q    <= address[31 -: TNUM];
                        index_q  <= address[6 +: INUM];
                        offset_q <= address[5:0];
                        state_q  <= StCompare;
                    end
                end
                StCompare: begin
                    if (hit) begin
                        lru_q[index_q] <= ~hit_way;
                        if (cnt_hit_q != '1) begin
                            cnt_hit_q <= cnt_hit_q + CNTW'(1);
                        end
                        state_q <= StIdle;
                    end else begin
                        victim_q  <= victim;
                        read_l2_q <= 1'b1;
                        if (cnt_miss_q != '1) begin
                            cnt_miss_q <= cnt_miss_q + CNTW'(1);
                        end
                        state_q <= StMiss;
                    end
                end
                StMiss: begin
                    if (ready_L2_L1) begin
                        read_l2_q <= 1'b0;
                        refill_q  <= 1'b1;
                        state_q   <= StRefill;
                    end
                end
                StRefill: begin
                    refill_q        <= 1'b0;
                    lru_q[index_q]  <= ~victim_q;
                    // Re-compare; the freshly written line must hit.
                    state_q         <= StCompare;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // The tag array answers within the compare cycle, so the hit path decodes it directly.
    assign cmp_hit       = (state_q == StCompare) && hit;
    assign ready_L1_C    = cmp_hit;
    assign way           = cmp_hit ? hit_way : (refill_q ? victim_q : 1'b0);
    assign index_C_L1    = index_q;
    assign offset        = offset_q;
    assign tag_C_L1      = tag_q;
    assign read_L1_L2    = read_l2_q;
    assign address_L1_L2 = read_l2_q ? {tag_q, index_q, 6'd0} : 32'd0;
    assign refill        = refill_q;
    assign update_tag    = refill_q;
    assign cnt_hit       = cnt_hit_q;
    assign cnt_miss      = cnt_miss_q;

endmodule
